// File: rtl/mul_accum.sv
// Frame accumulator for 7-bit products from the 4x3 multiply-add array.
// Sums len+1 beats, then holds the result until downstream takes it.
module mul_accum #(
   parameter int ACC_W = 11,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_data,
   input  logic [CNT_W-1:0] len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             live;
   logic [ACC_W:0]   sum;
   logic             take;

   // live keeps in_ready low until the first edge after reset release
   assign sum      = {1'b0, acc} + (ACC_W+1)'(in_data);
   assign in_ready = live & (state != HOLD);
   assign take     = in_valid & in_ready;

   assign out_valid = (state == HOLD);
   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         live  <= 1'b0;
      end else begin
         live <= 1'b1;
         case (state)
            IDLE: begin
               if (take) begin
                  acc   <= ACC_W'(in_data);
                  cnt   <= len;
                  ovf   <= 1'b0;
                  state <= (len == '0) ? HOLD : ACC;
               end
            end
            ACC: begin
               if (take) begin
                  acc <= sum[ACC_W-1:0];
                  ovf <= ovf | sum[ACC_W];
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1))
                     state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_accum.sv
// Directed bench for mul_accum: vector table plus corner sequences.
// Runs an 11-bit and a 9-bit instance on shared stimulus.
module tb_mul_accum;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  in_data = '0;
   logic [3:0]  len = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_ovf, busy;
   logic [10:0] out_sum;
   logic        in_ready9, out_valid9, out_ovf9, busy9;
   logic [8:0]  out_sum9;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mul_accum dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .len(len),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf),
      .busy(busy)
   );

   mul_accum #(.ACC_W(9), .CNT_W(4)) dut9 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready9),
      .in_data(in_data), .len(len),
      .out_valid(out_valid9), .out_ready(out_ready),
      .out_sum(out_sum9), .out_ovf(out_ovf9),
      .busy(busy9)
   );

   typedef struct {
      int l;
      int n;
      int b[4];
      int sum;
      int ovf;
   } vec_t;

   vec_t tv[5];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int l, input int n,
                          input int b0, input int b1,
                          input int b2, input int b3,
                          input int s, input int o);
      tv[i].l = l;
      tv[i].n = n;
      tv[i].b[0] = b0;
      tv[i].b[1] = b1;
      tv[i].b[2] = b2;
      tv[i].b[3] = b3;
      tv[i].sum = s;
      tv[i].ovf = o;
   endtask

   task automatic beat(input int d, input int l);
      in_valid = 1'b1;
      in_data = 7'(d);
      len = 4'(l);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      set_vec(0, 3, 4, 10, 20, 30, 40, 100, 0);
      set_vec(1, 0, 1, 127, 0, 0, 0, 127, 0);
      set_vec(2, 1, 2, 127, 127, 0, 0, 254, 0);
      set_vec(3, 2, 3, 0, 0, 0, 0, 0, 0);
      set_vec(4, 3, 4, 127, 1, 64, 3, 195, 0);

      #1;
      chk("rst in_ready", int'(in_ready), 0);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst out_sum", int'(out_sum), 0);
      chk("rst out_ovf", int'(out_ovf), 0);
      chk("rst busy", int'(busy), 0);
      idle(2);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("pre-edge in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("post-edge in_ready", int'(in_ready), 1);

      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < tv[i].n; j++) begin
            chk($sformatf("v%0d in_ready b%0d", i, j),
                int'(in_ready), 1);
            beat(tv[i].b[j], (j == 0) ? tv[i].l : 15);
            if (j < tv[i].n - 1)
               chk($sformatf("v%0d early valid", i),
                   int'(out_valid), 0);
         end
         chk($sformatf("v%0d out_valid", i), int'(out_valid), 1);
         chk($sformatf("v%0d in_ready hold", i), int'(in_ready), 0);
         chk($sformatf("v%0d out_sum", i), int'(out_sum), tv[i].sum);
         chk($sformatf("v%0d out_ovf", i), int'(out_ovf), tv[i].ovf);
         chk($sformatf("v%0d busy", i), int'(busy), 1);
         idle(1);
         chk($sformatf("v%0d valid after xfer", i), int'(out_valid), 0);
         chk($sformatf("v%0d busy after xfer", i), int'(busy), 0);
         chk($sformatf("v%0d sum kept", i), int'(out_sum), tv[i].sum);
      end
      out_ready = 1'b0;

      for (int j = 0; j < 16; j++) begin
         beat(127, (j == 0) ? 15 : 0);
         if (j == 3) begin
            chk("w9 sum 4 beats", int'(out_sum9), 508);
            chk("w9 ovf 4 beats", int'(out_ovf9), 0);
         end
         if (j == 4)
            chk("w9 ovf 5 beats", int'(out_ovf9), 1);
         if (j == 14)
            chk("w9 valid 15 beats", int'(out_valid9), 0);
      end
      chk("w9 out_valid", int'(out_valid9), 1);
      chk("w9 out_sum", int'(out_sum9), 496);
      chk("w9 out_ovf", int'(out_ovf9), 1);
      chk("w11 out_sum", int'(out_sum), 2032);
      chk("w11 out_ovf", int'(out_ovf), 0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      chk("w9 ovf kept", int'(out_ovf9), 1);
      beat(5, 0);
      chk("w9 next valid", int'(out_valid9), 1);
      chk("w9 next sum", int'(out_sum9), 5);
      chk("w9 next ovf", int'(out_ovf9), 0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      beat(1, 2);
      for (int g = 0; g < 3; g++) begin
         idle(1);
         chk("gap busy", int'(busy), 1);
         chk("gap valid", int'(out_valid), 0);
         chk("gap sum", int'(out_sum), 1);
      end
      beat(2, 0);
      idle(3);
      chk("gap sum 2", int'(out_sum), 3);
      beat(3, 0);
      in_valid = 1'b1;
      in_data = 7'd99;
      for (int h = 0; h < 5; h++) begin
         chk("hold valid", int'(out_valid), 1);
         chk("hold in_ready", int'(in_ready), 0);
         chk("hold sum", int'(out_sum), 6);
         idle(1);
      end
      in_valid = 1'b0;
      chk("hold sum end", int'(out_sum), 6);
      out_ready = 1'b1;
      idle(1);
      chk("gap xfer valid", int'(out_valid), 0);
      chk("gap xfer busy", int'(busy), 0);
      idle(1);
      chk("single xfer", int'(out_valid), 0);
      out_ready = 1'b0;

      beat(10, 3);
      beat(20, 3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid rst busy", int'(busy), 0);
      chk("mid rst sum", int'(out_sum), 0);
      chk("mid rst in_ready", int'(in_ready), 0);
      chk("mid rst valid", int'(out_valid), 0);
      #2;
      reset = 1'b1;
      idle(1);
      chk("after rst in_ready", int'(in_ready), 1);
      chk("after rst valid", int'(out_valid), 0);
      beat(7, 1);
      chk("new frame valid early", int'(out_valid), 0);
      beat(8, 1);
      chk("new frame valid", int'(out_valid), 1);
      chk("new frame sum", int'(out_sum), 15);
      chk("new frame ovf", int'(out_ovf), 0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      beat(1, 3);
      beat(2, 0);
      chk("len chg valid 2", int'(out_valid), 0);
      beat(3, 0);
      chk("len chg valid 3", int'(out_valid), 0);
      beat(4, 0);
      chk("len chg valid 4", int'(out_valid), 1);
      chk("len chg sum", int'(out_sum), 10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 The module SHALL have parameter ACC_W, default 11, giving the accumulator/result width in bits (minimum 7).
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the frame-length field width in bits.
REQ-003 Port: clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-005 Port: in_valid  input  1  upstream product beat present.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_data  input  7  unsigned product from the upstream 4x3 multiply-add array.
REQ-008 Port: len  input  CNT_W  frame length minus one; sampled only on the first beat of a frame.
REQ-009 Port: out_valid  output  1  frame result available.
REQ-010 Port: out_ready  input  1  downstream takes the result.
REQ-011 Port: out_sum  output  ACC_W  accumulated frame sum, registered.
REQ-012 Port: out_ovf  output  1  sticky overflow for the current or last frame.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Beat transfer SHALL occur when in_valid and in_ready are both high at a rising edge; result transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 The FSM SHALL have states IDLE, ACC, and HOLD.
REQ-016 In IDLE and ACC, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 On a beat in IDLE, the block SHALL load acc=in_data (zero-extended), load the remaining-beat counter with len, and clear ovf.
REQ-018 On a beat in IDLE with len=0, the next state SHALL be HOLD; otherwise it SHALL be ACC.
REQ-019 On a beat in ACC, the block SHALL set acc=acc+in_data modulo 2^ACC_W and decrement the counter.
REQ-020 On a beat in ACC where the counter was 1, the next state SHALL be HOLD.
REQ-021 A frame SHALL consist of exactly len+1 beats (1..2^CNT_W).
REQ-022 An ACC-state add whose true sum is at least 2^ACC_W SHALL set ovf, and ovf SHALL remain set until the next frame start or reset.
REQ-023 With in_valid low in ACC, acc, ovf, and the counter SHALL hold and the state SHALL stay ACC, with no timeout.
REQ-024 out_valid SHALL rise in the cycle after the edge that accepted the final beat (latency 1 cycle).
REQ-025 out_sum and out_ovf SHALL equal the final acc and ovf, and SHALL be stable while out_valid is high.
REQ-026 In HOLD, a result transfer SHALL return the FSM to IDLE; the next frame's first beat is accepted no earlier than the following edge (one-cycle bubble).
REQ-027 In HOLD with out_ready low, the block SHALL stay in HOLD indefinitely and hold its outputs.
REQ-028 out_ready SHALL be ignored outside HOLD.
REQ-029 len changes after the first beat SHALL have no effect on the current frame.
REQ-030 out_sum SHALL be retained after transfer and until the next frame's first beat; out_valid SHALL be 0 in IDLE and ACC.

Reset
REQ-031 While reset is low: state=IDLE, acc=0, counter=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, in_ready=0.
REQ-032 in_ready SHALL be 1 from the first rising edge after reset deasserts.
REQ-033 Reset asserted mid-frame or in HOLD SHALL abort the frame with no result emitted; the next frame SHALL start clean.

Verification
REQ-034 Scenario: len=3, beats 10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=100, out_ovf=0, busy falls after transfer.
REQ-035 Scenario: len=0, single beat 127 -> IDLE-to-HOLD directly, out_sum=127, out_ovf=0.
REQ-036 Scenario: ACC_W=9, len=15, sixteen beats of 127 -> out_sum=2032 mod 512=496, out_ovf=1; the next frame (len=0, beat 5) gives out_sum=5, out_ovf=0.
REQ-037 Scenario: len=2, beats 1,2,3 with in_valid gaps of 3 cycles, out_ready held low 5 cycles -> out_sum=6 stable, in_ready=0 throughout HOLD, then one transfer.
REQ-038 Scenario: reset pulsed low asynchronously (between edges) after 2 of 4 beats -> outputs cleared immediately; a new frame len=1 with beats 7,8 -> out_sum=15.
REQ-039 Scenario: len changed from 3 to 0 after the first beat of a frame -> the frame still takes 4 beats.
